// File: rtl/core_wb_arb.sv
// Writeback arbiter: picks one of N_SRC writeback sources per cycle (fixed
// priority or round-robin) and registers the winner into a one-entry regfile write stage.
module core_wb_arb #(
   parameter int N_SRC    = 4,
   parameter int XLEN     = 32,
   parameter int ARB_MODE = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_SRC-1:0]      src_valid,
   output logic [N_SRC-1:0]      src_ready,
   input  logic [N_SRC*5-1:0]    src_rd,
   input  logic [N_SRC*XLEN-1:0] src_data,
   input  logic                  reg_stall,
   input  logic                  flush,
   output logic                  reg_d_write,
   output logic [4:0]            reg_d_addr,
   output logic [XLEN-1:0]       reg_d_value,
   output logic                  busy
);

   localparam int PTR_W = $clog2(N_SRC);

   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] grant_idx;
   logic [PTR_W-1:0] scan_idx;
   logic [PTR_W:0]   scan_sum;
   logic             grant_found;
   logic             grant_allow;
   logic [4:0]       sel_rd;
   logic [XLEN-1:0]  sel_data;

   // Grant search: scan order starts at 0 (fixed) or rr_ptr (round-robin), wrapping at N_SRC.
   always_comb begin
      src_ready   = '0;
      grant_idx   = '0;
      grant_found = 1'b0;
      scan_idx    = '0;
      scan_sum    = '0;
      grant_allow = rst_n && !reg_stall && !flush;
      for (int i = 0; i < N_SRC; i++) begin
         if (ARB_MODE == 0) begin
            scan_sum = (PTR_W+1)'(i);
         end else begin
            scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (scan_sum >= (PTR_W+1)'(N_SRC)) begin
               scan_sum = scan_sum - (PTR_W+1)'(N_SRC);
            end
         end
         scan_idx = scan_sum[PTR_W-1:0];
         if (grant_allow && !grant_found && src_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
      if (grant_found) begin
         src_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (src_ready[i]) begin
            sel_rd   = src_rd[i*5 +: 5];
            sel_data = src_data[i*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (grant_found) begin
         rr_ptr <= (grant_idx == PTR_W'(N_SRC-1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Flush beats stall; writes to x0 complete the handshake but never assert write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_d_write <= 1'b0;
         reg_d_addr  <= '0;
         reg_d_value <= '0;
      end else if (flush) begin
         reg_d_write <= 1'b0;
      end else if (!reg_stall) begin
         if (grant_found) begin
            reg_d_write <= (sel_rd != 5'd0);
            reg_d_addr  <= sel_rd;
            reg_d_value <= sel_data;
         end else begin
            reg_d_write <= 1'b0;
         end
      end
   end

   assign busy = reg_stall & reg_d_write;

endmodule

// File: tb/tb_core_wb_arb.sv
// Drives a fixed-priority and a round-robin arbiter with the same stimulus and
// checks both against a cycle-level reference model of the writeback rules.
module tb_core_wb_arb;

   localparam int N    = 4;
   localparam int XLEN = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     src_valid;
   logic [N*5-1:0]   src_rd;
   logic [N*XLEN-1:0] src_data;
   logic             reg_stall;
   logic             flush;

   logic [N-1:0]     ready_fp, ready_rr;
   logic             write_fp, write_rr;
   logic [4:0]       addr_fp, addr_rr;
   logic [XLEN-1:0]  value_fp, value_rr;
   logic             busy_fp, busy_rr;

   int compared   = 0;
   int mismatched = 0;

   logic             m_write [2];
   logic [4:0]       m_addr  [2];
   logic [XLEN-1:0]  m_value [2];
   int               m_ptr   [2];
   logic [N-1:0]     last_ready [2];

   always #5 clk = ~clk;

   core_wb_arb #(.N_SRC(N), .XLEN(XLEN), .ARB_MODE(0)) dut_fp (
      .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(ready_fp),
      .src_rd(src_rd), .src_data(src_data), .reg_stall(reg_stall), .flush(flush),
      .reg_d_write(write_fp), .reg_d_addr(addr_fp), .reg_d_value(value_fp), .busy(busy_fp)
   );

   core_wb_arb #(.N_SRC(N), .XLEN(XLEN), .ARB_MODE(1)) dut_rr (
      .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(ready_rr),
      .src_rd(src_rd), .src_data(src_data), .reg_stall(reg_stall), .flush(flush),
      .reg_d_write(write_rr), .reg_d_addr(addr_rr), .reg_d_value(value_rr), .busy(busy_rr)
   );

   // Winner per the arbitration rule, or -1 when nothing is requesting.
   function automatic int pick(input int mode, input logic [N-1:0] v, input int ptr);
      int j;
      for (int k = 0; k < N; k++) begin
         j = (mode == 0) ? k : (ptr + k) % N;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         m_write[d] = 1'b0;
         m_addr[d]  = '0;
         m_value[d] = '0;
         m_ptr[d]   = 0;
      end
   endtask

   // One cycle: drive at negedge, check just after, advance the model, end on posedge.
   task automatic applyStimulus(input logic [N-1:0] v, input logic [N*5-1:0] rdv,
                                input logic [N*XLEN-1:0] datav, input logic st, input logic fl);
      int           g;
      logic [N-1:0] exp_ready;
      logic [N-1:0] obs_ready;
      string        nm;
      @(negedge clk);
      src_valid = v;
      src_rd    = rdv;
      src_data  = datav;
      reg_stall = st;
      flush     = fl;
      #1;
      for (int d = 0; d < 2; d++) begin
         nm = (d == 0) ? "fp" : "rr";
         g = (rst_n && !st && !fl) ? pick(d, v, m_ptr[d]) : -1;
         exp_ready = '0;
         if (g >= 0) exp_ready[g] = 1'b1;
         obs_ready = (d == 0) ? ready_fp : ready_rr;
         last_ready[d] = obs_ready;
         checkOutput({nm, ".ready"}, 64'(obs_ready), 64'(exp_ready));
         checkOutput({nm, ".write"}, 64'((d == 0) ? write_fp : write_rr), 64'(m_write[d]));
         checkOutput({nm, ".addr"},  64'((d == 0) ? addr_fp  : addr_rr),  64'(m_addr[d]));
         checkOutput({nm, ".value"}, 64'((d == 0) ? value_fp : value_rr), 64'(m_value[d]));
         checkOutput({nm, ".busy"},  64'((d == 0) ? busy_fp  : busy_rr),  64'(st ? m_write[d] : 1'b0));
         if (rst_n) begin
            if (fl) begin
               m_write[d] = 1'b0;
            end else if (!st) begin
               if (g >= 0) begin
                  m_addr[d]  = rdv[g*5 +: 5];
                  m_value[d] = datav[g*XLEN +: XLEN];
                  m_write[d] = (m_addr[d] != 5'd0);
                  m_ptr[d]   = (g + 1) % N;
               end else begin
                  m_write[d] = 1'b0;
               end
            end
         end
      end
      @(posedge clk);
   endtask

   initial begin
      logic [N*5-1:0]    r_rd;
      logic [N*XLEN-1:0] r_data;
      rst_n     = 1'b0;
      src_valid = '0;
      src_rd    = '0;
      src_data  = '0;
      reg_stall = 1'b0;
      flush     = 1'b0;
      modelReset();

      $display("[TB] reset state");
      applyStimulus(4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, '1, 1'b0, 1'b0);
      applyStimulus(4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, '1, 1'b0, 1'b0);
      @(negedge clk);
      src_valid = '0;
      rst_n     = 1'b1;

      $display("[TB] fixed priority example");
      applyStimulus(4'b1010, {5'd0, 5'd0, 5'd5, 5'd0}, {32'h0, 32'h0, 32'h11, 32'h0}, 1'b0, 1'b0);
      checkOutput("req033.ready", 64'(last_ready[0]), 64'(4'b0010));
      #1;
      checkOutput("req033.write", 64'(write_fp), 64'd1);
      checkOutput("req033.addr",  64'(addr_fp),  64'd5);
      checkOutput("req033.value", 64'(value_fp), 64'h11);

      $display("[TB] x0 write suppression");
      applyStimulus(4'b0001, '0, {96'h0, 32'hDEAD}, 1'b0, 1'b0);
      checkOutput("req035.ready", 64'(last_ready[0]), 64'(4'b0001));
      #1;
      checkOutput("req035.write", 64'(write_fp), 64'd0);

      $display("[TB] stall hold");
      applyStimulus(4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, {32'h0, 32'h0, 32'h77, 32'h0}, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {96'h0, 32'h33}, 1'b1, 1'b0);
         checkOutput("req036.noready", 64'(last_ready[0]), 64'd0);
      end
      applyStimulus(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {96'h0, 32'h33}, 1'b0, 1'b0);
      applyStimulus('0, '0, '0, 1'b0, 1'b0);

      $display("[TB] flush during stall");
      applyStimulus(4'b1000, {5'd9, 15'd0}, {32'h99, 96'h0}, 1'b0, 1'b0);
      applyStimulus(4'b1111, {5'd1, 5'd2, 5'd3, 5'd4}, '1, 1'b1, 1'b1);
      checkOutput("req037.noready", 64'(last_ready[1]), 64'd0);
      applyStimulus('0, '0, '0, 1'b1, 1'b0);

      $display("[TB] async reset mid-stall");
      applyStimulus(4'b0100, {5'd0, 5'd12, 10'd0}, {32'h0, 32'hC0C0, 64'h0}, 1'b0, 1'b0);
      applyStimulus('0, '0, '0, 1'b1, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("req038.write_fp", 64'(write_fp), 64'd0);
      checkOutput("req038.write_rr", 64'(write_rr), 64'd0);
      checkOutput("req038.busy_fp",  64'(busy_fp),  64'd0);
      checkOutput("req038.addr_rr",  64'(addr_rr),  64'd0);
      modelReset();
      src_valid = '0;
      reg_stall = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] round-robin rotation");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, 1'b0);
         checkOutput($sformatf("req034.grant%0d", i), 64'(last_ready[1]), 64'(1) << i);
      end
      applyStimulus(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, 1'b0);
      checkOutput("req034.wrap", 64'(last_ready[1]), 64'(4'b0001));

      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++) begin
         for (int s = 0; s < N; s++) begin
            r_rd[s*5 +: 5]        = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            r_data[s*XLEN +: XLEN] = $urandom;
         end
         applyStimulus(4'($urandom_range(0, 15)), r_rd, r_data,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      end
      applyStimulus('0, '0, '0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
